mux16_rr_arbiter: RTL and testbench
===================================

# mux16_rr_arbiter

Round-robin arbiter and sequencer that shares the 4-bit 16:1 multiplexer datapath among 16 requesters. It arbitrates requests, drives the mux select and captures the selected word into a registered output channel with a valid/ready handshake. It sits between 16 independent data sources and a single downstream consumer, and replaces free-running select counters with fair, demand-driven selection.

## Interface
- WIDTH, 4, data width per requester and of the output word
- NREQ, 16, number of requesters; fixed at 16 because sel is 4 bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  16  req[k] high means requester k holds a valid word on its data input
- din  input  16*WIDTH  flattened requester data; requester k at din[WIDTH*k +: WIDTH]
- grant  output  16  one-hot, registered; the requester currently owning the output
- ack  output  16  grant & {16{out_valid & out_ready}}; one-cycle completion pulse to the owner
- sel  output  4  registered select index of the current or last grant
- out_data  output  WIDTH  registered word captured from the granted requester
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts the word

## Operation
- State machine with two states:
  - IDLE: no word is held.
  - HOLD: out_valid is high.
- Round-robin pointer ptr[3:0] holds the highest-priority index. The search order is ptr, ptr+1, …, 15, 0, …, ptr-1, mod 16.
- IDLE with req != 0 at a clock edge:
  - The first requester w in search order wins.
  - sel <= w; grant <= 1<<w; out_data <= din[w]; out_valid <= 1.
  - Next state HOLD.
- IDLE with req == 0: nothing changes.
- HOLD without out_ready: grant, sel, out_data and out_valid stay stable. Changes on req and din are ignored.
- HOLD with out_ready (handshake at this edge): ack[sel] is high during this cycle, and ptr <= sel+1 (15 wraps to 0).
  - If req with bit sel masked is nonzero, re-arbitrate in the same edge using the new pointer, load the new grant and data, and stay in HOLD. This gives back-to-back transfers.
  - Otherwise, if only req[sel] is still high, regrant the same requester (new word), because it is the only requester.
  - Otherwise clear grant, set out_valid <= 0, go to IDLE. sel keeps its last value.
- A requester must hold req until it sees ack. Dropping req while granted does not cancel the transfer; the word is already captured.
- ptr updates only on a handshake, never on a grant.
- Reset values: grant=0, ack=0, sel=0, out_data=0, out_valid=0, ptr=0, state IDLE. Reset asserted mid-transfer discards the held word; no ack is issued.

## Timing
- Latency: req sampled high at edge t gives out_valid, grant and out_data at t+1 (one cycle).
- Throughput: one word per cycle while out_ready stays high and competing requests exist.
- ack is combinational from registered grant and out_valid plus the out_ready input. It is not registered.
- out_data never changes while out_valid=1 and out_ready=0.
- Fairness: with all 16 requesting continuously, each requester is served exactly once in any 16 consecutive handshakes.

## Structure
- Shared package/include `mux_defs`:
  - NREQ=16, SEL_W=4, WIDTH=4.
  - State encodings ST_IDLE=1'b0, ST_HOLD=1'b1.
- Sub-module: instantiate the existing `mux_16to1`.
  - Inputs: the 16 din slices, with sel driven by the combinational winner index.
  - Its output feeds the out_data register.
  - The round-robin priority search is a local function/always block, not a separate module.

## Test plan
- Single request: reset, then req=16'h0001, din slice0=4'hA, out_ready=1.
  - Next edge: out_valid=1, grant=16'h0001, sel=0, out_data=4'hA.
  - ack[0] pulses once; then out_valid=0; ptr=1.
- All request, ready stuck high, slices loaded 4'hA,4'hE,4'h2,…,4'h7:
  - sel sequence is 0,1,…,15,0 on consecutive cycles.
  - out_data follows the slices.
  - No idle cycle between words.
- Backpressure: req=16'h0009, out_ready=0 for 5 cycles.
  - sel=0 and out_data stable; din changes ignored.
  - Raise out_ready: handshake, then sel=3 next cycle.
- Wrap-around: ptr=15 (after serving 14), req=16'h8001.
  - Grant 15 first, then 0.
  - ptr ends at 1.
- Reset mid-operation: rst=1 while out_valid=1 and out_ready=0.
  - Next edge: all outputs 0, no ack pulse.
  - After release, the search restarts from ptr=0.
- Requester drops req while granted:
  - Word still delivered, ack issued.
  - No regrant if no other req is high.

Source files
------------

// File: rtl/mux_defs.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package mux_defs;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;
    localparam int WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/mux_16to1.sv
// 16:1 word multiplexer over a flattened input bus.
module mux_16to1
    import mux_defs::*;
(
    input  logic [NREQ*WIDTH-1:0] d_i,
    input  logic [SEL_W-1:0]      s_i,
    output logic [WIDTH-1:0]      y_o
);

    logic [WIDTH-1:0] slot [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_slot
        assign slot[k] = d_i[WIDTH*k +: WIDTH];
    end

    assign y_o = slot[s_i];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 mux among 16 requesters,
// with a registered valid/ready output channel.
module mux16_rr_arbiter
    import mux_defs::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] sel_q;
    logic [NREQ-1:0]  grant_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic             hs;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] win;
    logic [WIDTH-1:0] mux_y;

    // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NREQ-1:0]  r,
        input logic [SEL_W-1:0] p
    );
        logic [NREQ-1:0]  rot;
        logic [SEL_W-1:0] pos;
        rot = NREQ'({r, r} >> p);
        pos = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = SEL_W'(i);
        end
        return p + pos;
    endfunction

    assign hs = valid_q & out_ready;

    // Owner sits last in the search from sel+1, so it only wins if alone.
    assign ptr_d = hs ? sel_q + 1'b1 : ptr_q;
    assign win   = rr_pick(req, ptr_d);

    mux_16to1 u_mux (
        .d_i (din),
        .s_i (win),
        .y_o (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        sel_q   <= win;
                        grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        data_q  <= mux_y;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        ptr_q <= ptr_d;
                        if (|req) begin
                            sel_q   <= win;
                            grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                            data_q  <= mux_y;
                        end else begin
                            grant_q <= '0;
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ack       = grant_q & {NREQ{hs}};

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Randomised and directed checks of mux16_rr_arbiter against a
// transaction-level round-robin model.
module tb_mux16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [63:0] din;
    logic [15:0] grant;
    logic [15:0] ack;
    logic [3:0]  sel;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    // model state
    bit          m_valid;
    int          m_owner;
    int          m_ptr;
    int          m_sel;
    logic [3:0]  m_data;

    always #5 clk = ~clk;

    mux16_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .grant     (grant),
        .ack       (ack),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [15:0] r, input int p);
        for (int i = 0; i < 16; i++) begin
            if (r[(p + i) % 16]) return (p + i) % 16;
        end
        return -1;
    endfunction

    function automatic logic [15:0] m_grant();
        logic [15:0] g;
        g = '0;
        if (m_valid) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic void m_take(input logic [15:0] r, input logic [63:0] d);
        int w;
        w = first_from(r, m_ptr);
        if (w < 0) begin
            m_valid = 0;
        end else begin
            m_valid = 1;
            m_owner = w;
            m_sel   = w;
            m_data  = d[4*w +: 4];
        end
    endfunction

    task automatic step(input logic rs, input logic [15:0] r,
                        input logic [63:0] d, input logic rdy);
        rst = rs; req = r; din = d; out_ready = rdy;
        #1;
        chk("ack", 32'(ack), (m_valid && rdy) ? 32'(m_grant()) : 32'd0);
        @(posedge clk);
        if (rs) begin
            m_valid = 0; m_ptr = 0; m_sel = 0; m_data = '0;
        end else if (!m_valid) begin
            if (r != 0) m_take(r, d);
        end else if (rdy) begin
            m_ptr = (m_sel + 1) % 16;
            m_take(r, d);
        end
        #1;
        chk("grant", 32'(grant), 32'(m_grant()));
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("data", 32'(out_data), 32'(m_data));
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    localparam logic [63:0] DALL = 64'h7C3951F084D6B2EA;

    initial begin
        m_valid = 0; m_owner = 0; m_ptr = 0; m_sel = 0; m_data = '0;
        rst = 1'b1; req = '0; din = '0; out_ready = 1'b0;

        // reset state
        step(1, 16'h0000, 64'h0, 1'b0);
        step(1, 16'hFFFF, rnd64(), 1'b1);

        // single request, then dropped while granted
        step(0, 16'h0001, 64'hA, 1'b1);
        chk("single_data", 32'(out_data), 32'hA);
        chk("single_gnt", 32'(grant), 32'h0001);
        step(0, 16'h0000, 64'h0, 1'b1);
        chk("single_idle", 32'(out_valid), 32'd0);
        step(0, 16'h0002, 64'h50, 1'b1);
        chk("single_ptr1", 32'(sel), 32'd1);
        step(0, 16'h0000, 64'h0, 1'b1);

        // all requesting, ready high: sel 0..15,0 back to back
        step(1, 16'h0000, 64'h0, 1'b0);
        for (int k = 0; k < 17; k++) begin
            step(0, 16'hFFFF, DALL, 1'b1);
            chk("all_sel", 32'(sel), 32'(k % 16));
            chk("all_data", 32'(out_data), 32'(DALL[4*(k%16) +: 4]));
            chk("all_valid", 32'(out_valid), 32'd1);
        end
        step(0, 16'h0000, 64'h0, 1'b1);

        // backpressure
        step(1, 16'h0000, 64'h0, 1'b0);
        step(0, 16'h0009, 64'h0000_B00C, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(0, 16'h0009, rnd64(), 1'b0);
            chk("bp_sel", 32'(sel), 32'd0);
            chk("bp_data", 32'(out_data), 32'hC);
        end
        step(0, 16'h0008, 64'h0000_B00C, 1'b1);
        chk("bp_next", 32'(sel), 32'd3);
        step(0, 16'h0000, 64'h0, 1'b1);

        // wrap-around
        step(1, 16'h0000, 64'h0, 1'b0);
        step(0, 16'h4000, rnd64(), 1'b0);
        step(0, 16'h8001, rnd64(), 1'b1);
        chk("wrap15", 32'(sel), 32'd15);
        step(0, 16'h0001, rnd64(), 1'b1);
        chk("wrap0", 32'(sel), 32'd0);
        step(0, 16'h0000, 64'h0, 1'b1);
        step(0, 16'hFFFF, rnd64(), 1'b0);
        chk("wrap_ptr1", 32'(sel), 32'd1);

        // reset while holding with backpressure
        step(0, 16'hFFFF, rnd64(), 1'b1);
        step(0, 16'h0050, rnd64(), 1'b0);
        step(1, 16'h0050, rnd64(), 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        step(0, 16'h0050, rnd64(), 1'b0);
        chk("rst_ptr0", 32'(sel), 32'd4);

        // random
        step(1, 16'h0000, 64'h0, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] r;
            int mode;
            mode = $urandom_range(0, 3);
            case (mode)
                0: r = '0;
                1: r = 16'(1 << $urandom_range(0, 15));
                2: r = 16'($urandom) & 16'($urandom);
                default: r = 16'($urandom);
            endcase
            step(($urandom_range(0, 199) == 0), r, rnd64(),
                 ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
